dht22_read_scheduler: RTL and testbench

Sequences the DHT22 one-wire reader. Issues periodic and on-demand read requests, never faster than the sensor's minimum gap. Supervises each transaction with a timeout and abort, verifies the checksum, and counts errors. Latches validated humidity and temperature as scaled binary values for the clock's display path. The block sits between the reader (start/done handshake) and the display/formatting logic.

---
 rtl/dht22_read_scheduler_if.sv | 28 ++
 rtl/dht22_read_scheduler.sv | 211 +++++++++++++++++++++
 tb/tb_dht22_read_scheduler.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dht22_read_scheduler_if.sv
// Start/done handshake to the DHT22 reader plus the validated-sample bus
// towards the display path, bundled for the read scheduler.
interface dht22_read_scheduler_if;
  logic        enable;
  logic        force_read;
  logic        rd_start;
  logic        rd_done;
  logic [39:0] rd_data;
  logic        rd_abort;
  logic [15:0] humidity;
  logic [15:0] temperature;
  logic        data_valid;
  logic        new_sample;
  logic        sensor_fault;
  logic [7:0]  err_count;

  modport master (
    input  enable, force_read, rd_done, rd_data,
    output rd_start, rd_abort, humidity, temperature,
           data_valid, new_sample, sensor_fault, err_count
  );

  modport slave (
    output enable, force_read, rd_done, rd_data,
    input  rd_start, rd_abort, humidity, temperature,
           data_valid, new_sample, sensor_fault, err_count
  );
endinterface

// File: rtl/dht22_read_scheduler.sv
// DHT22 read scheduler: paces reader transactions, supervises them with a
// timeout, validates the checksum and latches scaled humidity/temperature.
module dht22_read_scheduler #(
  parameter int unsigned TICK_DIV   = 100000,
  parameter int unsigned PERIOD_MS  = 5000,
  parameter int unsigned MIN_GAP_MS = 2000,
  parameter int unsigned TIMEOUT_MS = 10,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic                           clk_100MHz,
  input  logic                           rst_DHT,
  dht22_read_scheduler_if.master         bus
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [15:0]   PERIOD_L  = 16'(PERIOD_MS);
  localparam logic [15:0]   GAP_L     = 16'(MIN_GAP_MS);
  localparam logic [15:0]   TMO_L     = 16'(TIMEOUT_MS);
  localparam logic [3:0]    RETRY_L   = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HOLD   = 3'd1,
    S_START  = 3'd2,
    S_ACTIVE = 3'd3,
    S_CHECK  = 3'd4
  } state_t;

  function automatic logic csum_ok(input logic [39:0] f);
    logic [7:0] s;
    s = f[39:32] + f[31:24] + f[23:16] + f[15:8];
    return (s == f[7:0]);
  endfunction

  function automatic logic [15:0] sm_to_tc(input logic [15:0] sm);
    logic [15:0] mag;
    mag = {1'b0, sm[14:0]};
    return sm[15] ? (16'd0 - mag) : mag;
  endfunction

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d, tick_adv;
  logic [15:0]   ms_q, ms_d, ms_adv;
  logic          pending_q, pending_d;
  logic [3:0]    retry_q, retry_d;
  logic [39:0]   frame_q, frame_d;
  logic          rd_start_q, rd_start_d;
  logic          rd_abort_q, rd_abort_d;
  logic [15:0]   hum_q, hum_d;
  logic [15:0]   temp_q, temp_d;
  logic          valid_q, valid_d;
  logic          new_q, new_d;
  logic          fault_q, fault_d;
  logic [7:0]    err_q, err_d;
  logic          fail, pass;
  logic [3:0]    retry_inc;
  logic          trip;

  // Timebase: all decisions use the post-edge elapsed value so that
  // intervals measured from rd_start come out exact.
  always_comb begin
    if (tick_q == TICK_LAST) begin
      tick_adv = '0;
      if (ms_q == 16'hFFFF) begin
        ms_adv = ms_q;
      end else begin
        ms_adv = ms_q + 16'd1;
      end
    end else begin
      tick_adv = tick_q + TW'(1);
      ms_adv   = ms_q;
    end
  end

  // Sequencer next-state and output computation.
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_adv;
    ms_d       = ms_adv;
    pending_d  = pending_q | bus.force_read;
    frame_d    = frame_q;
    rd_start_d = 1'b0;
    rd_abort_d = 1'b0;
    fail       = 1'b0;
    pass       = 1'b0;
    retry_inc  = retry_q + 4'd1;
    trip       = (retry_inc >= RETRY_L);

    case (state_q)
      S_IDLE: begin
        if (bus.enable) begin
          state_d = S_HOLD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HOLD: begin
        if (!bus.enable) begin
          state_d = S_IDLE;
        end else if ((ms_adv >= PERIOD_L) || (pending_q && (ms_adv >= GAP_L))) begin
          state_d    = S_START;
          tick_d     = '0;
          ms_d       = 16'd0;
          rd_start_d = 1'b1;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_START: begin
        state_d   = S_ACTIVE;
        pending_d = 1'b0;
      end
      S_ACTIVE: begin
        // A reply arriving on the timeout edge still counts as a reply.
        if (bus.rd_done) begin
          frame_d = bus.rd_data;
          state_d = S_CHECK;
        end else if (ms_adv == TMO_L) begin
          rd_abort_d = 1'b1;
          fail       = 1'b1;
          state_d    = S_HOLD;
        end else begin
          state_d = S_ACTIVE;
        end
      end
      S_CHECK: begin
        state_d = S_HOLD;
        if (csum_ok(frame_q)) begin
          pass = 1'b1;
        end else begin
          fail = 1'b1;
        end
      end
      default: begin
        state_d = S_HOLD;
      end
    endcase

    if (fail) begin
      err_d   = (err_q == 8'hFF) ? err_q : (err_q + 8'd1);
      retry_d = trip ? 4'd0 : retry_inc;
      fault_d = trip ? 1'b1 : fault_q;
      valid_d = trip ? 1'b0 : valid_q;
      hum_d   = hum_q;
      temp_d  = temp_q;
      new_d   = 1'b0;
    end else if (pass) begin
      err_d   = err_q;
      retry_d = 4'd0;
      fault_d = 1'b0;
      valid_d = 1'b1;
      hum_d   = frame_q[39:24];
      temp_d  = sm_to_tc(frame_q[23:8]);
      new_d   = 1'b1;
    end else begin
      err_d   = err_q;
      retry_d = retry_q;
      fault_d = fault_q;
      valid_d = valid_q;
      hum_d   = hum_q;
      temp_d  = temp_q;
      new_d   = 1'b0;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_100MHz) begin
    if (!rst_DHT) begin
      state_q    <= S_HOLD;
      tick_q     <= '0;
      ms_q       <= 16'd0;
      pending_q  <= 1'b0;
      retry_q    <= 4'd0;
      frame_q    <= 40'd0;
      rd_start_q <= 1'b0;
      rd_abort_q <= 1'b0;
      hum_q      <= 16'd0;
      temp_q     <= 16'd0;
      valid_q    <= 1'b0;
      new_q      <= 1'b0;
      fault_q    <= 1'b0;
      err_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      ms_q       <= ms_d;
      pending_q  <= pending_d;
      retry_q    <= retry_d;
      frame_q    <= frame_d;
      rd_start_q <= rd_start_d;
      rd_abort_q <= rd_abort_d;
      hum_q      <= hum_d;
      temp_q     <= temp_d;
      valid_q    <= valid_d;
      new_q      <= new_d;
      fault_q    <= fault_d;
      err_q      <= err_d;
    end
  end

  assign bus.rd_start     = rd_start_q;
  assign bus.rd_abort     = rd_abort_q;
  assign bus.humidity     = hum_q;
  assign bus.temperature  = temp_q;
  assign bus.data_valid   = valid_q;
  assign bus.new_sample   = new_q;
  assign bus.sensor_fault = fault_q;
  assign bus.err_count    = err_q;

endmodule

// File: tb/tb_dht22_read_scheduler.sv
// Scoreboard bench for dht22_read_scheduler: stimulus queues expected
// rd_start/rd_abort cycles and samples, a negedge monitor pops and compares.
module tb_dht22_read_scheduler;
  localparam int PERIOD_CYC = 500;
  localparam int GAP_CYC    = 200;
  localparam int TMO_CYC    = 50;

  localparam logic [39:0] F_GOOD = 40'h029200FF93;
  localparam logic [39:0] F_NEG  = 40'h01F48065DA;
  localparam logic [39:0] F_BAD  = 40'h029200FF00;

  typedef struct {
    int          at;
    logic [15:0] hum;
    logic [15:0] temp;
  } sample_t;

  logic clk_100MHz = 1'b0;
  logic rst_DHT;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_fail = 0;

  int      exp_start_q[$];
  int      exp_abort_q[$];
  sample_t exp_sample_q[$];

  dht22_read_scheduler_if bus ();

  dht22_read_scheduler #(
    .TICK_DIV  (10),
    .PERIOD_MS (50),
    .MIN_GAP_MS(20),
    .TIMEOUT_MS(5),
    .MAX_RETRY (3)
  ) dut (
    .clk_100MHz(clk_100MHz),
    .rst_DHT   (rst_DHT),
    .bus       (bus)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  always @(posedge clk_100MHz) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint expv);
    n_vec++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  endtask

  // Monitor: every DUT event must match the head of its expectation queue.
  always @(negedge clk_100MHz) begin
    if (bus.rd_start === 1'b1) begin
      if (exp_start_q.size() == 0) chk("unexpected rd_start", cyc, -1);
      else chk("rd_start cycle", cyc, exp_start_q.pop_front());
    end
    if (bus.rd_abort === 1'b1) begin
      if (exp_abort_q.size() == 0) chk("unexpected rd_abort", cyc, -1);
      else chk("rd_abort cycle", cyc, exp_abort_q.pop_front());
    end
    if (bus.new_sample === 1'b1) begin
      if (exp_sample_q.size() == 0) begin
        chk("unexpected new_sample", cyc, -1);
      end else begin
        sample_t e;
        e = exp_sample_q.pop_front();
        chk("sample cycle", cyc, e.at);
        chk("humidity", bus.humidity, e.hum);
        chk("temperature", bus.temperature, e.temp);
        chk("data_valid on sample", bus.data_valid, 1);
        chk("sensor_fault on sample", bus.sensor_fault, 0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_100MHz);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk_100MHz);
  endtask

  task automatic wait_start(output int c);
    c = -1;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk_100MHz);
      if (bus.rd_start === 1'b1) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL rd_start wait: none within 2000 cycles (cycle %0d)", cyc);
      finish_run();
    end
  endtask

  // Called at a negedge; reply sampled next edge, outputs visible one edge later.
  task automatic send_done(input logic [39:0] d, input logic good,
                           input logic [15:0] h, input logic [15:0] t, input logic frc);
    sample_t e;
    if (good) begin
      e.at = cyc + 2;
      e.hum = h;
      e.temp = t;
      exp_sample_q.push_back(e);
    end
    bus.rd_data    = d;
    bus.rd_done    = 1'b1;
    bus.force_read = frc;
    @(negedge clk_100MHz);
    bus.rd_done    = 1'b0;
    bus.force_read = 1'b0;
  endtask

  task automatic pulse_force();
    bus.force_read = 1'b1;
    @(negedge clk_100MHz);
    bus.force_read = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " humidity"}, bus.humidity, 0);
    chk({tag, " temperature"}, bus.temperature, 0);
    chk({tag, " data_valid"}, bus.data_valid, 0);
    chk({tag, " new_sample"}, bus.new_sample, 0);
    chk({tag, " sensor_fault"}, bus.sensor_fault, 0);
    chk({tag, " err_count"}, bus.err_count, 0);
    chk({tag, " rd_start"}, bus.rd_start, 0);
    chk({tag, " rd_abort"}, bus.rd_abort, 0);
  endtask

  initial begin
    int s;
    int e;
    rst_DHT        = 1'b0;
    bus.enable     = 1'b1;
    bus.force_read = 1'b0;
    bus.rd_done    = 1'b0;
    bus.rd_data    = 40'd0;
    tick(5);
    chk_all_zero("reset");

    // 1: power-up read governed by PERIOD_MS
    rst_DHT = 1'b1;
    exp_start_q.push_back(cyc + PERIOD_CYC);
    wait_start(s);
    tick(3);
    send_done(F_GOOD, 1'b1, 16'd658, 16'd255, 1'b0);

    // 3: bad checksum keeps the previous sample
    exp_start_q.push_back(s + PERIOD_CYC);
    wait_start(s);
    tick(3);
    send_done(F_BAD, 1'b0, 16'd0, 16'd0, 1'b0);
    tick(3);
    chk("bad csum err_count", bus.err_count, 1);
    chk("bad csum humidity", bus.humidity, 658);
    chk("bad csum temperature", bus.temperature, 255);
    chk("bad csum data_valid", bus.data_valid, 1);

    // 2: negative temperature
    exp_start_q.push_back(s + PERIOD_CYC);
    wait_start(s);
    tick(3);
    send_done(F_NEG, 1'b1, 16'd500, 16'hFF9B, 1'b0);
    tick(3);
    chk("neg temp err_count", bus.err_count, 1);

    // 4: three timeouts escalate to sensor_fault
    for (int i = 0; i < 3; i++) begin
      exp_start_q.push_back(s + PERIOD_CYC);
      wait_start(s);
      exp_abort_q.push_back(s + TMO_CYC);
      tick(60);
      chk("timeout sensor_fault", bus.sensor_fault, (i == 2) ? 1 : 0);
      chk("timeout data_valid", bus.data_valid, (i == 2) ? 0 : 1);
      chk("timeout err_count", bus.err_count, 2 + i);
    end
    exp_start_q.push_back(s + PERIOD_CYC);
    wait_start(s);
    tick(3);
    send_done(F_GOOD, 1'b1, 16'd658, 16'd255, 1'b0);
    tick(3);
    chk("recover sensor_fault", bus.sensor_fault, 0);
    chk("recover data_valid", bus.data_valid, 1);

    // 5: force_read gated by MIN_GAP, then immediate, then collapsed
    exp_start_q.push_back(s + GAP_CYC);
    wait_until(s + 100);
    pulse_force();
    wait_start(s);
    tick(3);
    send_done(F_NEG, 1'b1, 16'd500, 16'hFF9B, 1'b0);
    exp_start_q.push_back(s + 302);
    wait_until(s + 300);
    pulse_force();
    wait_start(s);
    tick(3);
    send_done(F_GOOD, 1'b1, 16'd658, 16'd255, 1'b0);
    exp_start_q.push_back(s + GAP_CYC);
    wait_until(s + 100);
    pulse_force();
    wait_until(s + 120);
    pulse_force();
    wait_start(s);
    tick(3);
    send_done(F_NEG, 1'b1, 16'd500, 16'hFF9B, 1'b0);
    exp_start_q.push_back(s + PERIOD_CYC);

    // 6a: disable during ACTIVE completes the read, then idles
    wait_start(s);
    tick(2);
    bus.enable = 1'b0;
    tick(2);
    send_done(F_GOOD, 1'b1, 16'd658, 16'd255, 1'b0);
    tick(700);
    e = cyc;
    exp_start_q.push_back(e + 2);
    bus.enable = 1'b1;
    wait_start(s);

    // 6b: reset during ACTIVE clears outputs without an abort
    tick(3);
    rst_DHT = 1'b0;
    tick(1);
    chk_all_zero("mid reset");
    tick(80);
    rst_DHT = 1'b1;
    exp_start_q.push_back(cyc + PERIOD_CYC);

    // 6c: err_count saturates at 255
    for (int i = 0; i < 260; i++) begin
      wait_start(s);
      tick(2);
      send_done(F_BAD, 1'b0, 16'd0, 16'd0, (i < 259) ? 1'b1 : 1'b0);
      if (i < 259) exp_start_q.push_back(s + GAP_CYC);
      tick(3);
      chk("saturating err_count", bus.err_count, (i < 255) ? (i + 1) : 255);
    end
    tick(10);
    chk("pending rd_start left", exp_start_q.size(), 0);
    chk("pending rd_abort left", exp_abort_q.size(), 0);
    chk("pending samples left", exp_sample_q.size(), 0);
    finish_run();
  end
endmodule
